// File: rtl/vga_timing_gen.sv
// VGA raster timing for the Pong display path: scan counters, syncs,
// and a pin stage delayed to line up with the renderer's colour output.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 1024,
    parameter int H_FP       = 24,
    parameter int H_SYNC     = 136,
    parameter int H_BP       = 160,
    parameter int V_ACTIVE   = 768,
    parameter int V_FP       = 3,
    parameter int V_SYNC     = 6,
    parameter int V_BP       = 29,
    parameter int SYNC_POL   = 0,
    parameter int PIPE_DELAY = 1
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [3:0]  vgaR_in,
    input  logic [3:0]  vgaG_in,
    input  logic [3:0]  vgaB_in,
    output logic [10:0] pixelx,
    output logic [10:0] pixely,
    output logic        video_on,
    output logic        frame_tick,
    output logic [3:0]  vgaRed,
    output logic [3:0]  vgaGreen,
    output logic [3:0]  vgaBlue,
    output logic        Hsync,
    output logic        Vsync
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        SP       = (SYNC_POL != 0);

    typedef struct packed {
        logic vid;
        logic hs;
        logic vs;
    } ctl_t;

    localparam ctl_t CTL_IDLE = '{vid: 1'b0, hs: ~SP, vs: ~SP};

    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;

    always_comb begin
        hcount_d = hcount_q + 11'd1;
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) begin
            hcount_d = 11'd0;
            if (vcount_q == V_LAST) begin
                vcount_d = 11'd0;
            end else begin
                vcount_d = vcount_q + 11'd1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            hcount_q <= 11'd0;
            vcount_q <= 11'd0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    ctl_t ctl0;
    ctl_t ctl_dly;

    always_comb begin
        ctl0.vid = (hcount_q < H_ACT) && (vcount_q < V_ACT);
        ctl0.hs  = (hcount_q >= HS_START && hcount_q < HS_END) ? SP : ~SP;
        ctl0.vs  = (vcount_q >= VS_START && vcount_q < VS_END) ? SP : ~SP;
    end

    assign pixelx     = hcount_q;
    assign pixely     = vcount_q;
    assign video_on   = ctl0.vid;
    assign frame_tick = (hcount_q == 11'd0) && (vcount_q == V_ACT);

    // Matches the renderer's latency so syncs/blank meet their colour.
    generate
        if (PIPE_DELAY == 0) begin : g_nodly
            assign ctl_dly = ctl0;
        end else begin : g_dly
            ctl_t dly_q [PIPE_DELAY];

            always_ff @(posedge pclk) begin
                if (reset) begin
                    for (int i = 0; i < PIPE_DELAY; i++) begin
                        dly_q[i] <= CTL_IDLE;
                    end
                end else begin
                    dly_q[0] <= ctl0;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end

            assign ctl_dly = dly_q[PIPE_DELAY-1];
        end
    endgenerate

    logic [11:0] rgb_q, rgb_d;
    logic        hs_q, vs_q;

    always_comb begin
        rgb_d = 12'h000;
        if (ctl_dly.vid) begin
            rgb_d = {vgaR_in, vgaG_in, vgaB_in};
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            rgb_q <= 12'h000;
            hs_q  <= ~SP;
            vs_q  <= ~SP;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= ctl_dly.hs;
            vs_q  <= ctl_dly.vs;
        end
    end

    assign vgaRed   = rgb_q[11:8];
    assign vgaGreen = rgb_q[7:4];
    assign vgaBlue  = rgb_q[3:0];
    assign Hsync    = hs_q;
    assign Vsync    = vs_q;

endmodule
